// File: rtl/escritura_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : escritura_pkg
//  Description : Shared definitions for the bus write controller.
//                Holds the state encoding, the default phase timings and the
//                width of the phase wait counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package escritura_pkg;

    // Controller states, 3-bit encoding. Codes 5..7 are unused and are
    // recovered to INICIO by the controller.
    typedef enum logic [2:0] {
        INICIO = 3'd0,
        DIR    = 3'd1,
        REC    = 3'd2,
        DATO   = 3'd3,
        FIN    = 3'd4
    } estado_t;

    // Default phase lengths in clock cycles (legal range 1..15)
    localparam int T_DIR_DEF  = 4;
    localparam int T_REC_DEF  = 2;
    localparam int T_DATO_DEF = 4;

    // Width of the phase wait counter
    localparam int ANCHO_CONT = 4;

endpackage : escritura_pkg
`default_nettype wire

// File: rtl/escritura_contador_espera.sv
`default_nettype none
// ============================================================================
//  Module      : contador_espera
//  Description : Loadable down-counter used to time each bus phase.
//                Loads 'valor' when 'carga' is high. Otherwise it counts down
//                and stops at zero, so it never wraps.
//  Ports       : clk   - system clock, rising edge
//                reset - asynchronous reset, active low
//                carga - load strobe
//                valor - value to load
//                cero  - high while the count is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module contador_espera
    import escritura_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  carga,
    input  logic [ANCHO_CONT-1:0] valor,
    output logic                  cero
);

    logic [ANCHO_CONT-1:0] r_cuenta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cuenta <= '0;
        end else if (carga) begin
            r_cuenta <= valor;
        end else if (r_cuenta != '0) begin
            r_cuenta <= r_cuenta - {{(ANCHO_CONT-1){1'b0}}, 1'b1};
        end
    end

    assign cero = (r_cuenta == '0);

endmodule : contador_espera
`default_nettype wire

// File: rtl/escritura.sv
`default_nettype none
// ============================================================================
//  Module      : escritura
//  Description : Write-transaction controller for the multiplexed
//                address/data register bus. On 'iniciar' it captures an
//                address and a data byte. It then drives an address phase,
//                a recovery gap and a data phase. Completion is flagged
//                until 'iniciar' is withdrawn.
//  Ports       : clk      - system clock, rising edge
//                reset    - asynchronous reset, active low
//                iniciar  - request level, held for the whole transaction
//                dir      - register address, sampled at start
//                dato     - data byte, sampled at start
//                ad_out   - value driven on the multiplexed bus
//                ad_oe    - bus output enable
//                cs_n     - chip select, active low
//                a_d      - phase select (0 address, 1 data)
//                wr_n     - write strobe, active low
//                ocupado  - transaction in progress on the bus
//                final_   - transaction complete, held until iniciar drops
//                           ('final' is a SystemVerilog keyword, so the port
//                           carries a trailing underscore)
//  Revision    : 1.0 - initial release
// ============================================================================
module escritura
    import escritura_pkg::*;
#(
    parameter int T_DIR  = T_DIR_DEF,
    parameter int T_REC  = T_REC_DEF,
    parameter int T_DATO = T_DATO_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [7:0] dir,
    input  logic [7:0] dato,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       a_d,
    output logic       wr_n,
    output logic       ocupado,
    output logic       final_
);

    // The counter is loaded with N-1 on phase entry. A phase therefore
    // lasts exactly N cycles, with the exit taken on the edge that sees zero.
    localparam logic [ANCHO_CONT-1:0] c_carga_dir  = ANCHO_CONT'(T_DIR  - 1);
    localparam logic [ANCHO_CONT-1:0] c_carga_rec  = ANCHO_CONT'(T_REC  - 1);
    localparam logic [ANCHO_CONT-1:0] c_carga_dato = ANCHO_CONT'(T_DATO - 1);

    estado_t               r_estado;
    estado_t               w_siguiente;
    logic                  w_carga;
    logic [ANCHO_CONT-1:0] w_valor;
    logic                  w_cero;
    logic                  w_inicio;

    logic [7:0]            r_dir;
    logic [7:0]            r_dato;

    logic [7:0]            w_ad_out;
    logic                  w_ad_oe;
    logic                  w_cs_n;
    logic                  w_a_d;
    logic                  w_wr_n;
    logic                  w_ocupado;
    logic                  w_final;

    logic [7:0]            r_ad_out;
    logic                  r_ad_oe;
    logic                  r_cs_n;
    logic                  r_a_d;
    logic                  r_wr_n;
    logic                  r_ocupado;
    logic                  r_final;

    // One wait counter is shared by all three bus phases
    contador_espera u_contador (
        .clk   (clk),
        .reset (reset),
        .carga (w_carga),
        .valor (w_valor),
        .cero  (w_cero)
    );

    assign w_inicio = (r_estado == INICIO) && iniciar;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado <= INICIO;
        end else begin
            r_estado <= w_siguiente;
        end
    end

    // Address and data are captured once, on the start edge only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dir  <= '0;
            r_dato <= '0;
        end else if (w_inicio) begin
            r_dir  <= dir;
            r_dato <= dato;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and counter control
    // ------------------------------------------------------------------
    always_comb begin
        w_siguiente = r_estado;
        w_carga     = 1'b0;
        w_valor     = '0;
        case (r_estado)
            INICIO: begin
                if (iniciar) begin
                    w_siguiente = DIR;
                    w_carga     = 1'b1;
                    w_valor     = c_carga_dir;
                end
            end
            DIR: begin
                if (!iniciar) begin
                    w_siguiente = INICIO;
                    w_carga     = 1'b1;
                end else if (w_cero) begin
                    w_siguiente = REC;
                    w_carga     = 1'b1;
                    w_valor     = c_carga_rec;
                end
            end
            REC: begin
                if (!iniciar) begin
                    w_siguiente = INICIO;
                    w_carga     = 1'b1;
                end else if (w_cero) begin
                    w_siguiente = DATO;
                    w_carga     = 1'b1;
                    w_valor     = c_carga_dato;
                end
            end
            DATO: begin
                if (!iniciar) begin
                    w_siguiente = INICIO;
                    w_carga     = 1'b1;
                end else if (w_cero) begin
                    w_siguiente = FIN;
                end
            end
            FIN: begin
                // A new write needs iniciar to drop for at least one edge
                if (!iniciar) begin
                    w_siguiente = INICIO;
                end
            end
            default: begin
                w_siguiente = INICIO;
                w_carga     = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the state being entered; registered below so the
    // bus pins are glitch-free flops with no path from the inputs.
    // ------------------------------------------------------------------
    always_comb begin
        w_ad_out  = '0;
        w_ad_oe   = 1'b0;
        w_cs_n    = 1'b1;
        w_a_d     = 1'b0;
        w_wr_n    = 1'b1;
        w_ocupado = 1'b0;
        w_final   = 1'b0;
        case (w_siguiente)
            DIR: begin
                // On the start edge the address register is still loading
                w_ad_out  = w_inicio ? dir : r_dir;
                w_ad_oe   = 1'b1;
                w_cs_n    = 1'b0;
                w_wr_n    = 1'b0;
                w_ocupado = 1'b1;
            end
            REC: begin
                w_ocupado = 1'b1;
            end
            DATO: begin
                w_ad_out  = r_dato;
                w_ad_oe   = 1'b1;
                w_cs_n    = 1'b0;
                w_a_d     = 1'b1;
                w_wr_n    = 1'b0;
                w_ocupado = 1'b1;
            end
            FIN: begin
                w_final   = 1'b1;
            end
            default: begin
                w_ad_out  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ad_out  <= '0;
            r_ad_oe   <= 1'b0;
            r_cs_n    <= 1'b1;
            r_a_d     <= 1'b0;
            r_wr_n    <= 1'b1;
            r_ocupado <= 1'b0;
            r_final   <= 1'b0;
        end else begin
            r_ad_out  <= w_ad_out;
            r_ad_oe   <= w_ad_oe;
            r_cs_n    <= w_cs_n;
            r_a_d     <= w_a_d;
            r_wr_n    <= w_wr_n;
            r_ocupado <= w_ocupado;
            r_final   <= w_final;
        end
    end

    assign ad_out  = r_ad_out;
    assign ad_oe   = r_ad_oe;
    assign cs_n    = r_cs_n;
    assign a_d     = r_a_d;
    assign wr_n    = r_wr_n;
    assign ocupado = r_ocupado;
    assign final_  = r_final;

endmodule : escritura
`default_nettype wire

// File: tb/tb_escritura.sv
`default_nettype none
// ============================================================================
//  Module      : tb_escritura
//  Description : Self-checking bench for the bus write controller. One
//                instance uses default timings, the other uses 1-cycle
//                phases. Expected bus states are queued by the stimulus and
//                compared by per-instance monitors after each rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_escritura;

    typedef struct packed {
        logic [7:0] ad;
        logic       oe;
        logic       cs_n;
        logic       a_d;
        logic       wr_n;
        logic       ocu;
        logic       fin;
    } salida_t;

    typedef struct {
        salida_t s;
        string   tag;
    } entrada_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic       ini_a = 1'b0;
    logic [7:0] dir_a = '0;
    logic [7:0] dato_a = '0;
    logic [7:0] ad_a;
    logic       oe_a, cs_a, ad_sel_a, wr_a, ocu_a, fin_a;

    logic       ini_b = 1'b0;
    logic [7:0] dir_b = '0;
    logic [7:0] dato_b = '0;
    logic [7:0] ad_b;
    logic       oe_b, cs_b, ad_sel_b, wr_b, ocu_b, fin_b;

    int errors = 0;
    int checks = 0;

    entrada_t q_a[$];
    entrada_t q_b[$];

    always #5 clk = ~clk;

    escritura u_dut (
        .clk(clk), .reset(reset), .iniciar(ini_a), .dir(dir_a), .dato(dato_a),
        .ad_out(ad_a), .ad_oe(oe_a), .cs_n(cs_a), .a_d(ad_sel_a),
        .wr_n(wr_a), .ocupado(ocu_a), .final_(fin_a)
    );

    escritura #(.T_DIR(1), .T_REC(1), .T_DATO(1)) u_dut_rapido (
        .clk(clk), .reset(reset), .iniciar(ini_b), .dir(dir_b), .dato(dato_b),
        .ad_out(ad_b), .ad_oe(oe_b), .cs_n(cs_b), .a_d(ad_sel_b),
        .wr_n(wr_b), .ocupado(ocu_b), .final_(fin_b)
    );

    // Expected bus states
    function automatic salida_t f_idle();
        return '{ad: 8'h00, oe: 1'b0, cs_n: 1'b1, a_d: 1'b0, wr_n: 1'b1, ocu: 1'b0, fin: 1'b0};
    endfunction
    function automatic salida_t f_dir(input logic [7:0] v);
        return '{ad: v, oe: 1'b1, cs_n: 1'b0, a_d: 1'b0, wr_n: 1'b0, ocu: 1'b1, fin: 1'b0};
    endfunction
    function automatic salida_t f_rec();
        return '{ad: 8'h00, oe: 1'b0, cs_n: 1'b1, a_d: 1'b0, wr_n: 1'b1, ocu: 1'b1, fin: 1'b0};
    endfunction
    function automatic salida_t f_dato(input logic [7:0] v);
        return '{ad: v, oe: 1'b1, cs_n: 1'b0, a_d: 1'b1, wr_n: 1'b0, ocu: 1'b1, fin: 1'b0};
    endfunction
    function automatic salida_t f_fin();
        return '{ad: 8'h00, oe: 1'b0, cs_n: 1'b1, a_d: 1'b0, wr_n: 1'b1, ocu: 1'b0, fin: 1'b1};
    endfunction

    function automatic salida_t act_a();
        return '{ad: ad_a, oe: oe_a, cs_n: cs_a, a_d: ad_sel_a, wr_n: wr_a, ocu: ocu_a, fin: fin_a};
    endfunction
    function automatic salida_t act_b();
        return '{ad: ad_b, oe: oe_b, cs_n: cs_b, a_d: ad_sel_b, wr_n: wr_b, ocu: ocu_b, fin: fin_b};
    endfunction

    task automatic comparar(input salida_t act, input salida_t exp_s, input string tag);
        checks++;
        if (act !== exp_s) begin
            errors++;
            $display("FAIL %s: actual {ad,oe,cs_n,a_d,wr_n,ocu,fin}=%h_%b%b%b%b%b%b required=%h_%b%b%b%b%b%b",
                     tag, act.ad, act.oe, act.cs_n, act.a_d, act.wr_n, act.ocu, act.fin,
                     exp_s.ad, exp_s.oe, exp_s.cs_n, exp_s.a_d, exp_s.wr_n, exp_s.ocu, exp_s.fin);
        end
    endtask

    // Drive inputs for the next edge and queue the state expected after it
    task automatic ciclo_a(input logic ini, input logic [7:0] d, input logic [7:0] v,
                           input salida_t e, input string tag);
        entrada_t en;
        @(negedge clk);
        ini_a = ini; dir_a = d; dato_a = v;
        en.s = e; en.tag = tag;
        q_a.push_back(en);
    endtask

    task automatic ciclo_b(input logic ini, input logic [7:0] d, input logic [7:0] v,
                           input salida_t e, input string tag);
        entrada_t en;
        @(negedge clk);
        ini_b = ini; dir_b = d; dato_b = v;
        en.s = e; en.tag = tag;
        q_b.push_back(en);
    endtask

    // Monitors: compare just after each rising edge
    initial begin : mon_a
        entrada_t en;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin
                en = q_a.pop_front();
                comparar(act_a(), en.s, en.tag);
            end
        end
    end

    initial begin : mon_b
        entrada_t en;
        forever begin
            @(posedge clk);
            #1;
            if (q_b.size() > 0) begin
                en = q_b.pop_front();
                comparar(act_b(), en.s, en.tag);
            end
        end
    end

    initial begin : estimulo
        // Reset state
        repeat (3) @(posedge clk);
        #2;
        comparar(act_a(), f_idle(), "reset_a");
        comparar(act_b(), f_idle(), "reset_b");
        @(negedge clk);
        reset = 1'b1;

        // Test 1: default timings, full transaction
        for (int i = 0; i < 4; i++) ciclo_a(1'b1, 8'h21, 8'h59, f_dir(8'h21), "t1_dir");
        for (int i = 0; i < 2; i++) ciclo_a(1'b1, 8'h21, 8'h59, f_rec(), "t1_rec");
        for (int i = 0; i < 4; i++) ciclo_a(1'b1, 8'h21, 8'h59, f_dato(8'h59), "t1_dato");
        for (int i = 0; i < 3; i++) ciclo_a(1'b1, 8'h21, 8'h59, f_fin(), "t1_fin");
        ciclo_a(1'b0, 8'h21, 8'h59, f_idle(), "t1_release");
        ciclo_a(1'b0, 8'h21, 8'h59, f_idle(), "t1_idle");

        // Tests 2 and 6: inputs change after start, iniciar held in FIN
        ciclo_a(1'b1, 8'h21, 8'h59, f_dir(8'h21), "t2_dir");
        for (int i = 0; i < 3; i++) ciclo_a(1'b1, 8'hFF, 8'hFF, f_dir(8'h21), "t2_dir");
        for (int i = 0; i < 2; i++) ciclo_a(1'b1, 8'hFF, 8'hFF, f_rec(), "t2_rec");
        for (int i = 0; i < 4; i++) ciclo_a(1'b1, 8'hFF, 8'hFF, f_dato(8'h59), "t2_dato");
        for (int i = 0; i < 20; i++) ciclo_a(1'b1, 8'hFF, 8'hFF, f_fin(), "t6_fin_hold");
        ciclo_a(1'b0, 8'h33, 8'h44, f_idle(), "t6_drop");
        for (int i = 0; i < 4; i++) ciclo_a(1'b1, 8'h33, 8'h44, f_dir(8'h33), "t6_dir2");
        for (int i = 0; i < 2; i++) ciclo_a(1'b1, 8'h33, 8'h44, f_rec(), "t6_rec2");
        for (int i = 0; i < 4; i++) ciclo_a(1'b1, 8'h33, 8'h44, f_dato(8'h44), "t6_dato2");
        ciclo_a(1'b1, 8'h33, 8'h44, f_fin(), "t6_fin2");
        ciclo_a(1'b0, 8'h33, 8'h44, f_idle(), "t6_release2");

        // Test 3: abort during the second data cycle
        for (int i = 0; i < 4; i++) ciclo_a(1'b1, 8'h5A, 8'hC3, f_dir(8'h5A), "t3_dir");
        for (int i = 0; i < 2; i++) ciclo_a(1'b1, 8'h5A, 8'hC3, f_rec(), "t3_rec");
        for (int i = 0; i < 2; i++) ciclo_a(1'b1, 8'h5A, 8'hC3, f_dato(8'hC3), "t3_dato");
        ciclo_a(1'b0, 8'h5A, 8'hC3, f_idle(), "t3_abort");
        for (int i = 0; i < 5; i++) ciclo_a(1'b0, 8'h5A, 8'hC3, f_idle(), "t3_no_final");

        // Test 4: asynchronous reset in the middle of the address phase
        for (int i = 0; i < 2; i++) ciclo_a(1'b1, 8'h77, 8'h88, f_dir(8'h77), "t4_dir");
        @(posedge clk);
        #3;
        reset = 1'b0;
        ini_a = 1'b0;
        #1;
        comparar(act_a(), f_idle(), "t4_async_reset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) ciclo_a(1'b0, 8'h77, 8'h88, f_idle(), "t4_quiet");
        ciclo_a(1'b1, 8'h12, 8'h34, f_dir(8'h12), "t4_restart");
        ciclo_a(1'b0, 8'h12, 8'h34, f_idle(), "t4_abort");

        // Test 5: one-cycle phases
        ciclo_b(1'b1, 8'h00, 8'hA5, f_dir(8'h00), "t5_dir");
        ciclo_b(1'b1, 8'h00, 8'hA5, f_rec(), "t5_rec");
        ciclo_b(1'b1, 8'h00, 8'hA5, f_dato(8'hA5), "t5_dato");
        ciclo_b(1'b1, 8'h00, 8'hA5, f_fin(), "t5_fin");
        ciclo_b(1'b1, 8'h00, 8'hA5, f_fin(), "t5_fin_hold");
        ciclo_b(1'b0, 8'h00, 8'hA5, f_idle(), "t5_release");

        // Drain both scoreboards within a bounded number of cycles
        for (int i = 0; i < 10 && (q_a.size() > 0 || q_b.size() > 0); i++) @(posedge clk);
        #2;
        if (q_a.size() > 0 || q_b.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: actual pending=%0d required pending=0", q_a.size() + q_b.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_escritura
`default_nettype wire

// File: doc/escritura.md
Name: escritura

Overview:
Write-transaction controller for the multiplexed address/data register bus. It is the write-side counterpart of the read controller.
- On `iniciar`, captures a register address and a data byte.
- Drives an address phase, a recovery gap, then a data phase on the bus, with programmable cycle counts.
- Reports completion on `final` until `iniciar` is withdrawn.
- Sits between the top-level sequencer and the bus pad logic, sharing the `iniciar`/`final` handshake used by the read controller.

Parameters:
- T_DIR, 4, cycles the address phase is held (legal 1..15)
- T_REC, 2, cycles of recovery gap between address and data phases (legal 1..15)
- T_DATO, 4, cycles the data phase is held (legal 1..15)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- iniciar  in  1  request; level held high by the sequencer for the whole transaction
- dir  in  8  register address, sampled at start
- dato  in  8  data byte, sampled at start
- ad_out  out  8  value driven on the multiplexed bus
- ad_oe  out  1  bus output enable (1 = drive ad_out)
- cs_n  out  1  chip select, active-low
- a_d  out  1  phase select: 0 = address, 1 = data
- wr_n  out  1  write strobe, active-low
- ocupado  out  1  high while a transaction is on the bus
- final  out  1  transaction complete, held until iniciar drops

Behaviour:
- Reset (reset=0, asynchronous):
  - state=INICIO; counter=0; address/data registers=0.
  - ad_out=0, ad_oe=0, cs_n=1, a_d=0, wr_n=1, ocupado=0, final=0.
- All outputs are flops updated on the same edge as the state register, so they reflect the state being entered. No combinational paths from inputs to outputs.
- States: INICIO, DIR, REC, DATO, FIN. Encoding 3 bits, defined in the package.
- INICIO: bus idle (reset values).
  - At an edge with iniciar=1: latch dir and dato, load counter=T_DIR-1, go to DIR.
- DIR: ad_oe=1, ad_out=dir_reg, a_d=0, cs_n=0, wr_n=0, ocupado=1.
  - Decrement counter each cycle.
  - At counter=0: load T_REC-1, go to REC.
- REC: cs_n=1, wr_n=1, ad_oe=0, ad_out=0, a_d=0, ocupado=1.
  - At counter=0: load T_DATO-1, go to DATO.
- DATO: ad_oe=1, ad_out=dato_reg, a_d=1, cs_n=0, wr_n=0, ocupado=1.
  - At counter=0: go to FIN.
- FIN: bus idle, ocupado=0, final=1.
  - Stay while iniciar=1.
  - At an edge with iniciar=0: go to INICIO, final=0.
- Latency: with start edge E0, cs_n falls after E0. final rises after edge E0+T_DIR+T_REC+T_DATO (defaults: E0+10).
- Phase lengths are exact: DIR lasts T_DIR cycles, REC lasts T_REC, DATO lasts T_DATO.
- Abort: iniciar=0 sampled in DIR, REC or DATO forces state INICIO and all outputs to reset values on that edge (one-cycle release). No final pulse follows.
- dir/dato changes after the start edge are ignored. Values are captured once per transaction.
- iniciar still high in FIN never starts a second transaction. A new write requires iniciar low for at least one edge.
- Reset asserted mid-transaction releases the bus immediately (asynchronous); cs_n=1 without waiting for a clock.
- Unused state encodings go to INICIO with reset outputs.
- Counter is 4 bits and never wraps. Reload happens only on a phase transition.

Decomposition:
- Package escritura_pkg holds:
  - state encodings (INICIO, DIR, REC, DATO, FIN);
  - default timing constants T_DIR=4, T_REC=2, T_DATO=4;
  - counter width 4.
- One sub-module, contador_espera: 4-bit loadable down-counter.
  - Ports: clk, reset, carga, valor[3:0], cero.
  - Same asynchronous active-low reset.
  - escritura instantiates it once for all three phases.

Test Plan:
1. Defaults; dir=8'h21, dato=8'h59, iniciar rises and is held:
   - 4 cycles of cs_n=0, a_d=0, wr_n=0, ad_out=21;
   - then 2 cycles of cs_n=1, ad_oe=0;
   - then 4 cycles of cs_n=0, a_d=1, ad_out=59;
   - then final=1, held until iniciar=0, then final=0 on the next edge.
2. dir/dato changed to 8'hFF one cycle after start -> the bus still shows 21 then 59.
3. iniciar dropped during the 2nd DATO cycle -> next edge: cs_n=1, wr_n=1, ad_oe=0, ocupado=0; final never rises.
4. reset=0 asserted mid-DIR between clock edges -> cs_n=1 and ad_oe=0 immediately. After release, no bus activity until iniciar is re-asserted.
5. T_DIR=1, T_REC=1, T_DATO=1; dir=8'h00, dato=8'hA5 -> each phase lasts exactly 1 cycle; final=1 after edge E0+3.
6. iniciar held high through FIN for 20 cycles -> exactly one transaction. Drop for 1 cycle then raise -> a second transaction starts.
